fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin arbiter sharing one fifo_queue write port between NREQ requesters.
- Valid/ready handshake per requester; registered write into the FIFO (fifo_we/fifo_d).
- Tracks FIFO occupancy plus its own in-flight write so it never writes into a full FIFO.
- Supports locked bursts, so one requester can land consecutive entries contiguously.

Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 32, data width; must match the FIFO WIDTH
- LENGTH, 8, FIFO depth; must match the FIFO LENGTH
- MAX_BURST, 4, maximum beats per locked burst (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester data valid
- req_lock  in  NREQ  per-requester burst-continue request, sampled on each accepted beat
- req_data  in  NREQ x WIDTH  per-requester data (unpacked array [NREQ])
- req_ready  out  NREQ  one-hot-or-zero accept
- fifo_used  in  $clog2(LENGTH)+2  FIFO occupied-entry count
- fifo_we  out  1  FIFO write enable, registered
- fifo_d  out  WIDTH  FIFO write data, registered
- grant_id  out  $clog2(NREQ)  current grantee index
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, fifo_we=0, fifo_d=0, req_ready=0, busy=0. An in-flight write is discarded. Stat counters clear.
- Credit = LENGTH - fifo_used - fifo_we, computed combinationally at WIDTH-safe size. Saturates at 0 and never goes negative.
- Winner = first req_valid index at or after rr_ptr, searching cyclically mod NREQ.
- States:
  - IDLE: if any req_valid, register the winner into grant_id and go to GRANT. req_ready=0 in IDLE.
  - GRANT: req_ready[grant_id] = req_valid[grant_id] && credit>0.
    - On a handshake: fifo_we<=1, fifo_d<=req_data[grant_id], rr_ptr<=grant_id+1 (wraps), beat_cnt<=1.
    - If req_lock[grant_id]=1, go to LOCK.
    - Otherwise, if another req_valid exists (grantee excluded), grant the new winner directly with no bubble. Else go to IDLE.
    - If req_valid[grant_id] drops before any handshake, go to IDLE next cycle.
  - LOCK: grant held; others see req_ready=0. On each handshake, beat_cnt increments.
    - Burst ends on a handshake with req_lock=0, or when beat_cnt reaches MAX_BURST (forced release). Next state then follows the GRANT release rules.
    - req_valid low in LOCK holds the grant and inserts a bubble.
- fifo_we defaults to 0 every cycle with no handshake. Latency: handshake at cycle N -> fifo_we=1 at N+1.
- Credit=0 stalls (ready=0) in any state; the grant is retained.
- Simultaneous requests: exactly one ready per cycle.
- rr_ptr wraps from NREQ-1 to 0.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined: adds output stat_grants [NREQ] x 16, one counter per requester. Each counter increments on every accepted beat, saturates at 16'hFFFF, and clears on reset.
- Undefined: port absent, no counters, zero area.

Decomposition:
- Package fifo_arb_pkg: typedef arb_state_t enum {IDLE, GRANT, LOCK}, and function rr_pick(valid, ptr) returning the winner index and a found flag.
- Sub-module rr_select: combinational cyclic priority search, parameterised by NREQ. It is reused by the future read-side scheduler.

Test Plan:
- Reset: rst=0 mid-burst, then release -> fifo_we=0, busy=0, grant_id=0; the next grant goes to the lowest valid requester.
- Fairness: all 4 req_valid held high, no lock -> fifo_d source order 0,1,2,3,0,1… with one write per cycle after the first grant.
- Lock: req0 lock=1 for 6 beats, MAX_BURST=4 -> req0 gets 4 consecutive writes, then req1 is granted.
- Full: fifo_used=7, LENGTH=8, two requesters valid -> one write, then req_ready=0 until fifo_used drops to 6 (counting the in-flight write).
- Withdrawal: req2 is granted then drops req_valid before ready -> IDLE next cycle, and rr_ptr is unchanged.
- Stats (FIFO_ARB_STATS_EN): 10 beats from req3 -> stat_grants[3]=10, others 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and the cyclic priority search used by the FIFO write arbiter
// and its rr_select helper.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } arb_state_t;

  // Widest requester vector the search function handles
  localparam int RR_MAX = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, searching cyclically over nreq bits
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input logic [3:0]        ptr,
                                       input int                nreq);
    rr_pick_t   r;
    logic [4:0] j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (i < nreq) begin
        j = {1'b0, ptr} + 5'(i);
        if (j >= 5'(nreq)) j = j - 5'(nreq);
        if (!r.found && valid[j[3:0]]) begin
          r.found = 1'b1;
          r.idx   = j[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_select.sv
// Combinational round-robin selector: lowest valid index at or after ptr,
// wrapping modulo NREQ. Shared with the read-side scheduler.
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  logic [RR_MAX-1:0] valid_ext;
  logic [3:0]        ptr_ext;
  rr_pick_t          pick;
  logic              unused_idx_bits;

  // Widen to the package search width and pick the winner
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    ptr_ext               = '0;
    ptr_ext[IW-1:0]       = ptr;
    pick                  = rr_pick(valid_ext, ptr_ext, NREQ);
    found                 = pick.found;
    idx                   = pick.idx[IW-1:0];
    unused_idx_bits       = ^pick.idx;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters,
// with credit tracking (occupancy plus in-flight write) and locked bursts.
// Optional per-requester grant counters: define FIFO_ARB_STATS_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 32,
  parameter int LENGTH    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_lock,
  input  logic [WIDTH-1:0]           req_data [NREQ],
  output logic [NREQ-1:0]            req_ready,
  input  logic [$clog2(LENGTH)+1:0]  fifo_used,
  output logic                       fifo_we,
  output logic [WIDTH-1:0]           fifo_d,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]                stat_grants [NREQ]
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int UW = $clog2(LENGTH) + 2;
  localparam int CW = UW + 2;
  localparam int BW = $clog2(MAX_BURST + 1);

  // Free entries can go negative transiently when fifo_used overshoots; clamp
  function automatic logic [CW-1:0] sat_credit(input logic signed [CW-1:0] raw);
    return (raw < 0) ? '0 : raw;
  endfunction

  arb_state_t           state;
  logic [IW-1:0]        rr_ptr;
  logic [BW-1:0]        beat_cnt;
  logic signed [CW-1:0] credit_raw;
  logic [CW-1:0]        credit;
  logic                 credit_ok;
  logic                 hs;
  logic [IW-1:0]        next_ptr;
  logic [NREQ-1:0]      others_valid;
  logic [BW-1:0]        beat_next;
  logic                 burst_end;
  logic                 win_found, rel_found;
  logic [IW-1:0]        win_idx, rel_idx;

  // Credit, handshake, and the one-hot ready toward the grantee
  always_comb begin
    credit_raw   = $signed(CW'(LENGTH)) - $signed({2'b00, fifo_used})
                 - $signed({{(CW-1){1'b0}}, fifo_we});
    credit       = sat_credit(credit_raw);
    credit_ok    = (credit != '0);
    hs           = (state != IDLE) && req_valid[grant_id] && credit_ok;
    req_ready    = '0;
    req_ready[grant_id] = hs;
    next_ptr     = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
    others_valid = req_valid & ~(NREQ'(1) << grant_id);
    beat_next    = beat_cnt + BW'(1);
    burst_end    = !req_lock[grant_id] || (beat_next >= BW'(MAX_BURST));
  end

  assign busy = (state != IDLE);

  // Winner from the round-robin pointer when starting from IDLE
  rr_select #(.NREQ(NREQ)) u_sel_idle (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (win_found),
    .idx   (win_idx)
  );

  // Next grantee on release, searched past the current one and excluding it
  rr_select #(.NREQ(NREQ)) u_sel_rel (
    .valid (others_valid),
    .ptr   (next_ptr),
    .found (rel_found),
    .idx   (rel_idx)
  );

  // Arbitration FSM with registered FIFO write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      fifo_we  <= 1'b0;
      fifo_d   <= '0;
    end else begin
      fifo_we <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_id <= win_idx;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (hs) begin
            fifo_we  <= 1'b1;
            fifo_d   <= req_data[grant_id];
            rr_ptr   <= next_ptr;
            beat_cnt <= BW'(1);
            if (req_lock[grant_id]) begin
              state <= LOCK;
            end else if (rel_found) begin
              grant_id <= rel_idx;
              state    <= GRANT;
            end else begin
              state <= IDLE;
            end
          end else if (!req_valid[grant_id]) begin
            state <= IDLE;
          end
        end
        LOCK: begin
          if (hs) begin
            fifo_we  <= 1'b1;
            fifo_d   <= req_data[grant_id];
            rr_ptr   <= next_ptr;
            beat_cnt <= beat_next;
            if (burst_end) begin
              if (rel_found) begin
                grant_id <= rel_idx;
                state    <= GRANT;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Per-requester accepted-beat counters, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) stat_grants[i] <= '0;
    end else if (hs) begin
      stat_grants[grant_id] <= sat_inc16(stat_grants[grant_id]);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: stimulus pushes expected FIFO
// writes, a negedge monitor pops and compares on every fifo_we.
module tb_fifo_write_arbiter;

  localparam int NREQ = 4, WIDTH = 32, LENGTH = 8, MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_lock = '0;
  logic [31:0] req_data [NREQ];
  logic [3:0]  req_ready;
  logic [4:0]  fifo_used = '0;
  logic        fifo_we;
  logic [31:0] fifo_d;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_grants [NREQ];
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  fifo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LENGTH(LENGTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_used (fifo_used),
    .fifo_we   (fifo_we),
    .fifo_d    (fifo_d),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every FIFO write must match the head of the expected queue
  always @(negedge clk) begin
    if (rst && fifo_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %h expected no write", fifo_d);
      end else begin
        chk("fifo_d", fifo_d, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int phase);
    for (int i = 0; i < NREQ; i++) req_data[i] = (32'(phase) << 28) | 32'(i);
  endtask

  task automatic push(input int phase, input int src);
    exp_q.push_back((32'(phase) << 28) | 32'(src));
  endtask

  task automatic expect_ready(input string name, input logic [3:0] exp);
    @(negedge clk);
    chk(name, {28'd0, req_ready}, {28'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    tick(); tick(); tick();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    set_data(1);

    // Reset state
    #12;
    chk("rst_we", {31'd0, fifo_we}, 0);
    chk("rst_d", fifo_d, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_gid", {30'd0, grant_id}, 0);
    chk("rst_ready", {28'd0, req_ready}, 0);
    tick();
    rst = 1'b1;

    // Fairness: all valid, no lock -> 0,1,2,3,0,1,2,3 one per cycle
    set_data(2);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) push(2, k % 4);
    tick();
    chk("fair_busy", {31'd0, busy}, 1);
    for (int k = 0; k < 8; k++) expect_ready("fair_ready", 4'(1 << (k % 4)));
    req_valid = '0;
    drain("fair_drain");
    chk("fair_idle", {31'd0, busy}, 0);

    // Lock: req0 holds lock, forced release after MAX_BURST beats, then req1
    set_data(3);
    req_valid = 4'b0011;
    req_lock  = 4'b0001;
    for (int k = 0; k < 4; k++) push(3, 0);
    push(3, 1);
    tick();
    for (int k = 0; k < 4; k++) expect_ready("lock_ready0", 4'b0001);
    expect_ready("lock_ready1", 4'b0010);
    req_valid = '0;
    req_lock  = '0;
    drain("lock_drain");

    // Full: fifo_used=7 -> one write, stall while in flight and while full
    set_data(4);
    fifo_used = 5'd7;
    req_valid = 4'b1100;
    push(4, 2);
    push(4, 3);
    tick();
    expect_ready("full_first", 4'b0100);
    req_valid = 4'b1000;
    expect_ready("full_inflight", 4'b0000);
    fifo_used = 5'd8;
    expect_ready("full_stall", 4'b0000);
    expect_ready("full_stall", 4'b0000);
    chk("full_gid", {30'd0, grant_id}, 3);
    chk("full_busy", {31'd0, busy}, 1);
    fifo_used = 5'd6;
    expect_ready("full_resume", 4'b1000);
    req_valid = '0;
    drain("full_drain");
    fifo_used = '0;

    // Withdrawal: req2 granted under stall, drops valid -> IDLE, pointer kept
    set_data(5);
    fifo_used = 5'd8;
    req_valid = 4'b0100;
    tick();
    chk("wd_gid", {30'd0, grant_id}, 2);
    chk("wd_busy", {31'd0, busy}, 1);
    chk("wd_ready", {28'd0, req_ready}, 0);
    req_valid = '0;
    tick();
    chk("wd_idle", {31'd0, busy}, 0);
    fifo_used = '0;
    req_valid = 4'b1010;
    push(5, 1);
    push(5, 3);
    tick();
    chk("wd_ptr_gid", {30'd0, grant_id}, 1);
    expect_ready("wd_ready1", 4'b0010);
    expect_ready("wd_ready3", 4'b1000);
    req_valid = '0;
    drain("wd_drain");

    // Reset mid-burst: in-flight write discarded, restart from lowest valid
    set_data(6);
    req_valid = 4'b0001;
    req_lock  = 4'b0001;
    tick();
    expect_ready("mid_pre", 4'b0001);
    rst = 1'b0;
    #1;
    chk("mid_we", {31'd0, fifo_we}, 0);
    chk("mid_busy", {31'd0, busy}, 0);
    chk("mid_gid", {30'd0, grant_id}, 0);
    chk("mid_ready", {28'd0, req_ready}, 0);
    req_valid = 4'b0110;
    req_lock  = '0;
    tick();
    rst = 1'b1;
    push(6, 1);
    push(6, 2);
    tick();
    chk("mid_regrant", {30'd0, grant_id}, 1);
    expect_ready("mid_ready1", 4'b0010);
    expect_ready("mid_ready2", 4'b0100);
    req_valid = '0;
    drain("mid_drain");

    // Ten beats from req3 after a fresh reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("stat_clear", {16'd0, stat_grants[i]}, 0);
`endif
    set_data(7);
    for (int k = 0; k < 10; k++) push(7, 3);
    req_valid = 4'b1000;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 10; c++) begin
      @(negedge clk);
      if (req_ready[3]) cnt++;
      @(posedge clk);
      #1;
      if (cnt == 10) req_valid = '0;
    end
    req_valid = '0;
    chk("beats10", cnt, 10);
    drain("beats_drain");
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("stat_grants", {16'd0, stat_grants[i]}, (i == 3) ? 10 : 0);
`endif

    chk("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
